// File: rtl/arm7tdmi_pkg.sv
// Shared types and helpers for the ARM7TDMI memory-bus models.
// Holds the memory FSM state encoding, abort-mode layout and byte-merge helper.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

  // Bit ABORT_RD aborts reads, bit ABORT_WR aborts writes; 2'b00 disables the region.
  typedef logic [1:0] abort_mode_t;

  localparam int ABORT_RD = 0;
  localparam int ABORT_WR = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/arm7tdmi_abort_mem_abort_region_match.sv
// Combinational abort-region lookup: an address hits when it falls inside any
// enabled region whose mode bit matches the access kind.
module abort_region_match
  import arm7tdmi_pkg::*;
#(
  parameter int NUM_REGIONS = 4
) (
  input  logic [31:0]                   addr,
  input  logic                          wr,
  input  logic [NUM_REGIONS-1:0][31:0]  base,
  input  logic [NUM_REGIONS-1:0][31:0]  limit,
  input  abort_mode_t [NUM_REGIONS-1:0] mode,
  output logic                          hit
);

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      // A region with base > limit can never satisfy both bounds, so it never matches.
      if ((base[i] <= addr) && (addr <= limit[i]) &&
          (wr ? mode[i][ABORT_WR] : mode[i][ABORT_RD])) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arm7tdmi_abort_mem.sv
// ARM7TDMI bus memory model with wait states, programmable abort regions and abort logging.
// The backing array keeps its contents across reset; all control state is reset.
module arm7tdmi_abort_mem
  import arm7tdmi_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          NUM_REGIONS = 4,
  parameter int          WAIT_STATES = 0,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] OOR_DATA    = 32'hDEADBEEF,
  localparam int         IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_be,
  input  logic             mem_re,
  input  logic             mem_we,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic             mem_abort,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_base,
  input  logic [31:0]      cfg_limit,
  input  logic [1:0]       cfg_mode,
  output logic [CNT_W-1:0] abort_count,
  output logic [31:0]      abort_addr,
  output logic             abort_wr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_e state;
  logic [31:0] mem [DEPTH_WORDS];

  logic [NUM_REGIONS-1:0][31:0]  reg_base;
  logic [NUM_REGIONS-1:0][31:0]  reg_limit;
  abort_mode_t [NUM_REGIONS-1:0] reg_mode;

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_wr;
  logic        acc_hit;
  logic [3:0]  wait_cnt;

  logic        hit;
  logic [31:0] rd_addr;
  logic        rd_wr;
  logic        rd_hit;
  logic [31:0] rd_value;

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(DEPTH_WORDS);
  endfunction

  // Evaluated against the live request with the pre-edge config, so a same-cycle cfg write is not seen.
  abort_region_match #(
    .NUM_REGIONS(NUM_REGIONS)
  ) u_match (
    .addr  (mem_addr),
    .wr    (mem_we),
    .base  (reg_base),
    .limit (reg_limit),
    .mode  (reg_mode),
    .hit   (hit)
  );

  // Response data comes from the live request when entering RESP straight from IDLE.
  always_comb begin
    rd_addr  = (state == MEM_IDLE) ? mem_addr : acc_addr;
    rd_wr    = (state == MEM_IDLE) ? mem_we   : acc_wr;
    rd_hit   = (state == MEM_IDLE) ? hit      : acc_hit;
    rd_value = '0;
    if (!rd_wr && !rd_hit) begin
      rd_value = in_range(rd_addr) ? mem[rd_addr[AW+1:2]] : OOR_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_base  <= '0;
      reg_limit <= '0;
      reg_mode  <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      reg_base[cfg_idx]  <= cfg_base;
      reg_limit[cfg_idx] <= cfg_limit;
      reg_mode[cfg_idx]  <= cfg_mode;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MEM_IDLE;
      mem_ready   <= 1'b0;
      mem_abort   <= 1'b0;
      mem_rdata   <= '0;
      abort_count <= '0;
      abort_addr  <= '0;
      abort_wr    <= 1'b0;
      acc_addr    <= '0;
      acc_wdata   <= '0;
      acc_be      <= '0;
      acc_wr      <= 1'b0;
      acc_hit     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      unique case (state)
        MEM_IDLE: begin
          if (mem_re || mem_we) begin
            acc_addr  <= mem_addr;
            acc_wdata <= mem_wdata;
            acc_be    <= mem_be;
            acc_wr    <= mem_we;
            acc_hit   <= hit;
            wait_cnt  <= '0;
            if (WAIT_STATES == 0) begin
              state     <= MEM_RESP;
              mem_ready <= 1'b1;
              mem_abort <= rd_hit;
              mem_rdata <= rd_value;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            state     <= MEM_RESP;
            mem_ready <= 1'b1;
            mem_abort <= rd_hit;
            mem_rdata <= rd_value;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        MEM_RESP: begin
          state     <= MEM_IDLE;
          mem_ready <= 1'b0;
          mem_abort <= 1'b0;
          mem_rdata <= '0;
          if (acc_hit) begin
            if (abort_count != {CNT_W{1'b1}}) abort_count <= abort_count + 1'b1;
            abort_addr <= acc_addr;
            abort_wr   <= acc_wr;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  // NOTE: the backing array is deliberately left out of reset so contents survive it and map to RAM.
  always_ff @(posedge clk) begin
    if ((state == MEM_RESP) && acc_wr && !acc_hit && in_range(acc_addr)) begin
      mem[acc_addr[AW+1:2]] <= merge_bytes(mem[acc_addr[AW+1:2]], acc_wdata, acc_be);
    end
  end

endmodule

// File: tb/tb_arm7tdmi_abort_mem.sv
// Randomized self-checking bench: two instances (no wait states / 8-bit counter, and
// three wait states / 2-bit counter) compared against a behavioural model of the bus rules.
module tb_arm7tdmi_abort_mem;

  localparam logic [31:0] OOR = 32'hDEADBEEF;
  localparam int          DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic        re [2];
  logic        we [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        abort [2];
  logic        cfg_we [2];
  logic [1:0]  cfg_idx [2];
  logic [31:0] cfg_base [2];
  logic [31:0] cfg_limit [2];
  logic [1:0]  cfg_mode [2];
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [31:0] aaddr [2];
  logic        awr [2];

  arm7tdmi_abort_mem u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_be(be[0]),
    .mem_re(re[0]), .mem_we(we[0]),
    .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mem_abort(abort[0]),
    .cfg_we(cfg_we[0]), .cfg_idx(cfg_idx[0]), .cfg_base(cfg_base[0]),
    .cfg_limit(cfg_limit[0]), .cfg_mode(cfg_mode[0]),
    .abort_count(cnt0), .abort_addr(aaddr[0]), .abort_wr(awr[0])
  );

  arm7tdmi_abort_mem #(.WAIT_STATES(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_be(be[1]),
    .mem_re(re[1]), .mem_we(we[1]),
    .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mem_abort(abort[1]),
    .cfg_we(cfg_we[1]), .cfg_idx(cfg_idx[1]), .cfg_base(cfg_base[1]),
    .cfg_limit(cfg_limit[1]), .cfg_mode(cfg_mode[1]),
    .abort_count(cnt1), .abort_addr(aaddr[1]), .abort_wr(awr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-instance memory image, region table and abort log.
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  logic [31:0] m_base  [2][4];
  logic [31:0] m_limit [2][4];
  logic [1:0]  m_mode  [2][4];
  int          m_cnt   [2];
  logic [31:0] m_aaddr [2];
  bit          m_awr   [2];
  int          wait_of [2] = '{0, 3};
  int          cnt_max [2] = '{255, 3};
  logic [31:0] pool    [14];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 1) ? 32'(cnt1) : 32'(cnt0);
  endfunction

  function automatic bit model_hit(input int d, input logic [31:0] a, input bit wr);
    for (int i = 0; i < 4; i++) begin
      if (m_mode[d][i][wr] && (m_base[d][i] <= a) && (a <= m_limit[d][i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_base[d][i]  = '0;
        m_limit[d][i] = '0;
        m_mode[d][i]  = 2'b00;
      end
      m_cnt[d]   = 0;
      m_aaddr[d] = '0;
      m_awr[d]   = 1'b0;
    end
  endfunction

  task automatic stage_cfg(input int d, input int idx, input logic [31:0] b,
                           input logic [31:0] l, input logic [1:0] m);
    cfg_idx[d]   = 2'(idx);
    cfg_base[d]  = b;
    cfg_limit[d] = l;
    cfg_mode[d]  = m;
  endtask

  function automatic void model_apply_cfg(input int d);
    m_base[d][cfg_idx[d]]  = cfg_base[d];
    m_limit[d][cfg_idx[d]] = cfg_limit[d];
    m_mode[d][cfg_idx[d]]  = cfg_mode[d];
  endfunction

  task automatic cfg_write(input int d, input int idx, input logic [31:0] b,
                           input logic [31:0] l, input logic [1:0] m);
    @(negedge clk);
    stage_cfg(d, idx, b, l, m);
    cfg_we[d] = 1'b1;
    @(negedge clk);
    cfg_we[d] = 1'b0;
    model_apply_cfg(d);
  endtask

  // One bus access; cfg_at<0 means no cfg strobe, 0 strobes with the request,
  // k>0 strobes on the k-th cycle after the accept edge if the access is still pending.
  task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input int cfg_at);
    bit          hit;
    bit          inr;
    bit          cfg_done;
    int          cyc;
    int          widx;
    logic [31:0] exp_rd;
    hit      = model_hit(d, a, w);
    inr      = (a[31:2] < 30'(DEPTH));
    widx     = inr ? int'(a[31:2]) : 0;
    exp_rd   = (w || hit) ? 32'h0 : (inr ? m_mem[d][widx] : OOR);
    cfg_done = (cfg_at == 0);
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; be[d] = b; we[d] = w; re[d] = r;
    if (cfg_at == 0) cfg_we[d] = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      cfg_we[d] = 1'b0;
      if (ready[d]) break;
      if (cyc == cfg_at) begin
        cfg_we[d] = 1'b1;
        cfg_done  = 1'b1;
      end
    end
    cfg_we[d] = 1'b0;
    check($sformatf("latency d%0d a=%h", d, a), cyc, wait_of[d] + 1);
    if (ready[d]) begin
      check($sformatf("abort d%0d a=%h", d, a), abort[d], hit);
      if (w || hit || !inr || m_known[d][widx])
        check($sformatf("rdata d%0d a=%h", d, a), rdata[d], exp_rd);
    end
    re[d] = 1'b0;
    we[d] = 1'b0;
    if (hit) begin
      if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
      m_aaddr[d] = a;
      m_awr[d]   = w;
    end else if (w && inr) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_mem[d][widx][8*k +: 8] = wd[8*k +: 8];
      if (b == 4'hF) m_known[d][widx] = 1'b1;
    end
    if (cfg_done) model_apply_cfg(d);
    @(negedge clk);
    check($sformatf("ready pulse d%0d", d), ready[d], 1'b0);
    check($sformatf("abort_count d%0d", d), cnt_of(d), m_cnt[d]);
    check($sformatf("abort_addr d%0d", d), aaddr[d], m_aaddr[d]);
    check($sformatf("abort_wr d%0d", d), awr[d], m_awr[d]);
  endtask

  initial begin
    pool = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h2000, 32'h2004, 32'h2FF8,
             32'h2FFC, 32'h3000, 32'h3FFC, 32'h4000, 32'h10000, 32'hFFFFFFFC};
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < DEPTH; j++) begin
        m_mem[d][j]   = '0;
        m_known[d][j] = 1'b0;
      end
      addr[d] = '0; wdata[d] = '0; be[d] = '0; re[d] = 1'b0; we[d] = 1'b0;
      cfg_we[d] = 1'b0;
      stage_cfg(d, 0, '0, '0, 2'b00);
    end
    model_reset();

    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready d%0d", d), ready[d], 1'b0);
      check($sformatf("reset abort d%0d", d), abort[d], 1'b0);
      check($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset count d%0d", d), cnt_of(d), 32'h0);
      check($sformatf("reset aaddr d%0d", d), aaddr[d], 32'h0);
      check($sformatf("reset awr d%0d", d), awr[d], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every in-range pool word while no region is active.
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 11; p++) access(d, 1'b1, 1'b0, pool[p], $urandom, 4'hF, -1);

    // T1: plain read, one-cycle latency.
    access(0, 1'b1, 1'b0, 32'h0, 32'hE3A00001, 4'hF, -1);
    access(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, -1);

    // T2: write-abort region; the aborted store leaves memory untouched.
    cfg_write(0, 0, 32'h2000, 32'h2FFF, 2'b10);
    access(0, 1'b1, 1'b0, 32'h2000, 32'h42, 4'hF, -1);
    access(0, 1'b0, 1'b1, 32'h2000, 32'h0, 4'h0, -1);

    // T3: mode selectivity and inclusive limit.
    access(0, 1'b0, 1'b1, 32'h2FFC, 32'h0, 4'h0, -1);
    cfg_write(0, 0, 32'h2000, 32'h2FFF, 2'b11);
    access(0, 1'b0, 1'b1, 32'h3000, 32'h0, 4'h0, -1);
    access(0, 1'b0, 1'b1, 32'h2FFF, 32'h0, 4'h0, -1);

    // Both strobes high: a write with zero read data, partial byte enables.
    access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5_5A5A, 4'b0101, -1);
    access(0, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, -1);

    // T4: wait states; cfg changes mid-access or in the accept cycle only affect later accesses.
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, -1);
    stage_cfg(1, 0, 32'h0, 32'hF, 2'b01);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 2);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, -1);
    stage_cfg(1, 0, 32'h0, 32'hF, 2'b00);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 0);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, -1);

    // T5: counter saturation, out-of-range read and dropped write.
    cfg_write(1, 1, 32'h0, 32'hF, 2'b11);
    for (int k = 0; k < 5; k++) access(1, k[0], ~k[0], 32'h8, $urandom, 4'hF, -1);
    access(1, 1'b0, 1'b1, 32'h10000, 32'h0, 4'h0, -1);
    access(1, 1'b1, 1'b0, 32'h10000, 32'h1234, 4'hF, -1);
    access(1, 1'b0, 1'b1, 32'h10000, 32'h0, 4'h0, -1);

    // T6: reset while dut1 waits and dut0 sits in RESP with an abort.
    @(negedge clk);
    addr[1] = 32'h4; re[1] = 1'b1;
    @(negedge clk);
    addr[0] = 32'h2FFF; re[0] = 1'b1;
    @(negedge clk);
    check("pre-reset ready d0", ready[0], 1'b1);
    check("pre-reset abort d0", abort[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async ready d0", ready[0], 1'b0);
    check("async abort d0", abort[0], 1'b0);
    check("async ready d1", ready[1], 1'b0);
    check("async abort d1", abort[1], 1'b0);
    re[0] = 1'b0; re[1] = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, -1);
      access(d, 1'b0, 1'b1, 32'h2FFC, 32'h0, 4'h0, -1);
    end

    // Randomized mix of config writes and accesses.
    for (int it = 0; it < 250; it++) begin
      int          d;
      int          op;
      int          cat;
      logic [31:0] b;
      logic [31:0] l;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      b  = pool[$urandom_range(0, 13)];
      l  = ($urandom_range(0, 4) == 0) ? b - 32'h4 : b + 32'($urandom_range(0, 32'h1100));
      if (op < 2) begin
        cfg_write(d, int'($urandom_range(0, 3)), b, l, 2'($urandom));
      end else begin
        cat = -1;
        if ($urandom_range(0, 2) == 0) begin
          cat = (d == 1) ? int'($urandom_range(0, 4)) : 0;
          stage_cfg(d, int'($urandom_range(0, 3)), b, l, 2'($urandom));
        end
        access(d, (op >= 6), (op < 6) || (op == 9),
               pool[$urandom_range(0, 13)] | 32'($urandom_range(0, 3)),
               $urandom, 4'($urandom), cat);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
